// File: rtl/regfile_sb_if.sv
// Bus bundle between the ID/WB stages (master) and the register file with pending scoreboard (slave).
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] src;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rpend;
  logic                     wb_en;
  logic [ADDR_W-1:0]        dest_wb;
  logic [DATA_W-1:0]        result_wb;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_dest;
  logic                     flush;
  logic [ADDR_W:0]          pend_cnt;

  modport master (
    output src, wb_en, dest_wb, result_wb, iss_en, iss_dest, flush,
    input  rdata, rpend, pend_cnt
  );

  modport slave (
    input  src, wb_en, dest_wb, result_wb, iss_en, iss_dest, flush,
    output rdata, rpend, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register pending scoreboard for the hazard unit.
// Optional REGFILE_BYPASS_EN forwards a same-cycle write-back onto the read ports.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 15,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]      pend_q, pend_d;
  logic [ADDR_W:0]          pend_cnt_q, pend_cnt_d;
  logic [NUM_RD*DATA_W-1:0] rdata_c;
  logic [NUM_RD-1:0]        rpend_c;

  always_comb begin
    regs_d     = regs_q;
    pend_d     = pend_q;
    pend_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!ZR || i != 0) begin
        if (bus.wb_en && bus.dest_wb == ADDR_W'(i)) begin
          regs_d[i] = bus.result_wb;
          pend_d[i] = 1'b0;
        end
        // Issue after write-back: the new producer keeps the bit set.
        if (bus.iss_en && bus.iss_dest == ADDR_W'(i)) begin
          pend_d[i] = 1'b1;
        end
      end
    end
    if (bus.flush) begin
      pend_d = '0;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  localparam logic [ADDR_W:0] NREG = (ADDR_W+1)'(NUM_REGS);
  logic wb_ok;
  assign wb_ok = bus.wb_en && ({1'b0, bus.dest_wb} < NREG) && !(ZR && bus.dest_wb == '0);
`endif

  always_comb begin
    rdata_c = '0;
    rpend_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if ((!ZR || i != 0) && bus.src[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
          rdata_c[k*DATA_W +: DATA_W] = regs_q[i];
          rpend_c[k]                  = pend_q[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (wb_ok && bus.src[k*ADDR_W +: ADDR_W] == bus.dest_wb) begin
        rdata_c[k*DATA_W +: DATA_W] = bus.result_wb;
        rpend_c[k]                  = bus.iss_en && (bus.iss_dest == bus.dest_wb);
      end
`endif
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.rpend    = rpend_c;
  assign bus.pend_cnt = pend_cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters, bypass on or off).
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(15), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_en     = 1'b0;
    bus.dest_wb   = '0;
    bus.result_wb = '0;
    bus.iss_en    = 1'b0;
    bus.iss_dest  = '0;
    bus.flush     = 1'b0;
  endtask

  function automatic logic [31:0] rd0();
    return bus.rdata[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return bus.rdata[63:32];
  endfunction

  initial begin
    idle();
    bus.src = '0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset contents on port 0, all 16 addresses
    for (int a = 0; a < 16; a++) begin
      bus.src[3:0] = 4'(a);
      #1;
      chk($sformatf("rst_rdata_r%0d", a), 64'(rd0()), (a == 0 || a == 15) ? 64'd0 : 64'(a));
      chk($sformatf("rst_rpend_r%0d", a), 64'(bus.rpend[0]), 64'd0);
    end
    chk("rst_pend_cnt", 64'(bus.pend_cnt), 64'd0);

    // Write r3 with same-cycle read
    bus.src       = {4'd0, 4'd3};
    bus.wb_en     = 1'b1;
    bus.dest_wb   = 4'd3;
    bus.result_wb = 32'hDEADBEEF;
    #1;
    chk("wr_r3_same_cycle", 64'(rd0()), BYP ? 64'hDEADBEEF : 64'd3);
    tick();
    idle();
    #1;
    chk("wr_r3_next_cycle", 64'(rd0()), 64'hDEADBEEF);

    // Issue r5, r7, r5
    bus.iss_en = 1'b1;
    bus.iss_dest = 4'd5; tick();
    bus.iss_dest = 4'd7; tick();
    bus.iss_dest = 4'd5; tick();
    idle();
    bus.src = {4'd7, 4'd5};
    #1;
    chk("iss_rpend_r5_r7", 64'(bus.rpend), 64'b11);
    chk("iss_pend_cnt_2", 64'(bus.pend_cnt), 64'd2);

    // Write-back r5
    bus.wb_en     = 1'b1;
    bus.dest_wb   = 4'd5;
    bus.result_wb = 32'h1234;
    #1;
    chk("wb_r5_same_rpend", 64'(bus.rpend[0]), BYP ? 64'd0 : 64'd1);
    tick();
    idle();
    #1;
    chk("wb_r5_rpend", 64'(bus.rpend), 64'b10);
    chk("wb_r5_pend_cnt", 64'(bus.pend_cnt), 64'd1);
    chk("wb_r5_rdata", 64'(rd0()), 64'h1234);

    // Same-cycle issue and write-back on r9
    bus.src       = {4'd7, 4'd9};
    bus.wb_en     = 1'b1;
    bus.dest_wb   = 4'd9;
    bus.result_wb = 32'h99;
    bus.iss_en    = 1'b1;
    bus.iss_dest  = 4'd9;
    #1;
    chk("r9_same_rdata", 64'(rd0()), BYP ? 64'h99 : 64'd9);
    chk("r9_same_rpend", 64'(bus.rpend[0]), BYP ? 64'd1 : 64'd0);
    tick();
    idle();
    #1;
    chk("r9_rpend_after", 64'(bus.rpend), 64'b11);
    chk("r9_pend_cnt", 64'(bus.pend_cnt), 64'd2);
    chk("r9_rdata_after", 64'(rd0()), 64'h99);

    // Issue r1, r2, r4 then flush with issue r6
    bus.iss_en = 1'b1;
    bus.iss_dest = 4'd1; tick();
    bus.iss_dest = 4'd2; tick();
    bus.iss_dest = 4'd4; tick();
    idle();
    #1;
    chk("pre_flush_pend_cnt", 64'(bus.pend_cnt), 64'd5);
    bus.flush     = 1'b1;
    bus.iss_en    = 1'b1;
    bus.iss_dest  = 4'd6;
    bus.wb_en     = 1'b1;
    bus.dest_wb   = 4'd2;
    bus.result_wb = 32'h22;
    tick();
    idle();
    bus.src = {4'd6, 4'd2};
    #1;
    chk("flush_pend_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("flush_rpend_r2_r6", 64'(bus.rpend), 64'b00);
    chk("flush_keeps_write", 64'(rd0()), 64'h22);
    bus.src = {4'd9, 4'd1};
    #1;
    chk("flush_rpend_r1_r9", 64'(bus.rpend), 64'b00);

    // Zero register and out-of-range destinations are ignored
    bus.src       = {4'd15, 4'd0};
    bus.wb_en     = 1'b1;
    bus.dest_wb   = 4'd0;
    bus.result_wb = 32'h55;
    bus.iss_en    = 1'b1;
    bus.iss_dest  = 4'd0;
    #1;
    chk("r0_same_rdata", 64'(rd0()), 64'd0);
    tick();
    idle();
    #1;
    chk("r0_rdata", 64'(rd0()), 64'd0);
    chk("r0_rpend", 64'(bus.rpend), 64'b00);
    chk("r0_pend_cnt", 64'(bus.pend_cnt), 64'd0);
    bus.wb_en     = 1'b1;
    bus.dest_wb   = 4'd15;
    bus.result_wb = 32'h77;
    bus.iss_en    = 1'b1;
    bus.iss_dest  = 4'd15;
    tick();
    idle();
    #1;
    chk("r15_rdata", 64'(rd1()), 64'd0);
    chk("r15_pend_cnt", 64'(bus.pend_cnt), 64'd0);

    // Top valid register r14
    bus.src       = {4'd14, 4'd0};
    bus.wb_en     = 1'b1;
    bus.dest_wb   = 4'd14;
    bus.result_wb = 32'hE0E0;
    bus.iss_en    = 1'b1;
    bus.iss_dest  = 4'd14;
    tick();
    idle();
    #1;
    chk("r14_rdata", 64'(rd1()), 64'hE0E0);
    chk("r14_rpend", 64'(bus.rpend), 64'b10);
    chk("r14_pend_cnt", 64'(bus.pend_cnt), 64'd1);

    // Reset mid-sequence with a write and issue pending
    bus.wb_en     = 1'b1;
    bus.dest_wb   = 4'd10;
    bus.result_wb = 32'hAAAA;
    bus.iss_en    = 1'b1;
    bus.iss_dest  = 4'd11;
    tick();
    idle();
    bus.src = {4'd11, 4'd10};
    #1;
    chk("pre_rst_r10", 64'(rd0()), 64'hAAAA);
    chk("pre_rst_pend_cnt", 64'(bus.pend_cnt), 64'd2);
    rst           = 1'b1;
    bus.wb_en     = 1'b1;
    bus.dest_wb   = 4'd10;
    bus.result_wb = 32'hBBBB;
    bus.iss_en    = 1'b1;
    bus.iss_dest  = 4'd12;
    bus.flush     = 1'b0;
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_mid_r10", 64'(rd0()), 64'd10);
    chk("rst_mid_r11_rpend", 64'(bus.rpend), 64'b00);
    chk("rst_mid_pend_cnt", 64'(bus.pend_cnt), 64'd0);
    bus.src = {4'd14, 4'd3};
    #1;
    chk("rst_mid_r3", 64'(rd0()), 64'd3);
    chk("rst_mid_r14", 64'(rd1()), 64'd14);
    bus.src = {4'd5, 4'd12};
    #1;
    chk("rst_mid_rpend_r12_r5", 64'(bus.rpend), 64'b00);
    chk("rst_mid_r5", 64'(rd1()), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the pipeline's 15-entry register file. It adds N combinational read ports, one write-back port, and a per-register pending scoreboard for the hazard unit. Issue-stage writes set a register's pending bit and write-back clears it, so decode sees both operand data and operand readiness. It sits between the ID stage (reads, issue) and the WB stage (write).

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 4: register address width.
- `NUM_REGS`, default 15: implemented registers, indices 0..NUM_REGS-1. Must be ≤ 2^ADDR_W.
- `NUM_RD`, default 2: number of read ports.
- `ZERO_REG`, default 1: when 1, register 0 is hard-wired to 0.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `src`, in, NUM_RD*ADDR_W: read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- `rdata`, out, NUM_RD*DATA_W: read data; port k uses [k*DATA_W +: DATA_W].
- `rpend`, out, NUM_RD: bit k is the pending flag of the register addressed by port k.
- `wb_en`, in, 1: write-back strobe.
- `dest_wb`, in, ADDR_W: write-back address.
- `result_wb`, in, DATA_W: write-back data.
- `iss_en`, in, 1: issue strobe; marks `iss_dest` pending.
- `iss_dest`, in, ADDR_W: destination register being issued.
- `flush`, in, 1: clears every pending bit.
- `pend_cnt`, out, ADDR_W+1: registered count of pending registers.

## Operation
- Storage: `regs[0..NUM_REGS-1]` (DATA_W each) and `pend[0..NUM_REGS-1]` (1 bit each).
- Reset (`rst` high at a rising edge):
  - `regs[i]` ← i, zero-extended or truncated to DATA_W.
  - All `pend` bits ← 0 and `pend_cnt` ← 0.
  - Reset has priority over `wb_en`, `iss_en` and `flush` in the same cycle.
- Write: on a rising edge with `wb_en`=1, `regs[dest_wb]` ← `result_wb`.
  - The write is ignored if `dest_wb` ≥ NUM_REGS, or if ZERO_REG=1 and `dest_wb`=0.
- Read: combinational.
  - `rdata[k]` = `regs[src[k]]`.
  - Returns 0 if `src[k]` ≥ NUM_REGS, or if ZERO_REG=1 and `src[k]`=0.
  - `rpend[k]` = `pend[src[k]]`; it is 0 for out-of-range addresses and for the zero register.
- Scoreboard update at each rising edge, in priority order:
  - `flush` clears all bits.
  - Otherwise `wb_en` clears `pend[dest_wb]`, then `iss_en` sets `pend[iss_dest]`.
  - Issue and write-back to the same register in the same cycle leave the bit set, because the new producer wins.
  - Issue to an already-pending register leaves it pending (no nesting count).
  - `flush` together with `iss_en` leaves all bits clear; the issue is discarded.
  - `flush` does not block the data write.
  - Invalid or zero-register `iss_dest`/`dest_wb` is ignored.
- `pend_cnt`: registered population count of `pend`, updated on the same edge as `pend`, so it always equals popcount of the post-edge `pend`.

## Timing
- Write-to-register latency: 1 edge. Without bypass, data is visible on `rdata` from the cycle after `wb_en`.
- `rpend` reflects the state after the edge. After an issue at edge t, `rpend`=1 from cycle t+1.
- With bypass (see Configuration), a same-cycle write-back is visible combinationally:
  - `rdata` shows `result_wb`.
  - `rpend` shows 0 unless `iss_en` targets the same register in the same cycle.
- Zero-cycle path from `src` to `rdata`/`rpend`; no output registers except `pend_cnt`.
- After reset release, all outputs follow the reset contents: `rdata[k]` = `src[k]` (in range), `rpend` = 0, `pend_cnt` = 0.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - When `wb_en`=1 and `src[k]`==`dest_wb` (valid, non-zero register), `rdata[k]` = `result_wb`.
  - In the same case, `rpend[k]` = 1 only if `iss_en` && `iss_dest`==`src[k]`; otherwise 0.
- `REGFILE_BYPASS_EN` undefined: reads see only stored state; the write-before-read hazard is left to the forwarding unit.

## Test plan
- Reset, then read all 16 addresses on port 0 → `rdata` = 0..14 for r0–r14, except r0 reads 0 (ZERO_REG=1); r15 reads 0; `pend_cnt` = 0.
- Write r3=0xDEADBEEF with `src[0]`=3 in the same cycle → without the macro `rdata[0]` is old value 3, then 0xDEADBEEF next cycle; with the macro it is 0xDEADBEEF in the same cycle.
- Issue r5, r7, r5 on three consecutive cycles → `rpend` for r5 and r7 is 1, `pend_cnt` = 2; write-back r5 → r5 pend 0, `pend_cnt` = 1.
- Same cycle `iss_en` r9 and `wb_en` r9 → r9 remains pending; `pend_cnt` increments by 1.
- Issue r1, r2, r4, then `flush` with `iss_en` r6 → all `rpend` = 0, `pend_cnt` = 0.
- Write r0=0x55 and issue r0 → `rdata` for r0 stays 0, `rpend` 0; assert `rst` mid-sequence with `wb_en`=1 → contents revert to index values, nothing written.
